// File: rtl/ram_512_pkg.sv
// Shared definitions for the voice-path frame buffers: default geometry and the
// read-during-write behaviour these RAMs are built around.
package ram_512_pkg;

  localparam int RAM_DATA_WIDTH = 16;
  localparam int RAM_ADDR_WIDTH = 9;

  typedef enum logic [1:0] {
    RDW_OLD_DATA  = 2'd0,
    RDW_NEW_DATA  = 2'd1,
    RDW_DONT_CARE = 2'd2
  } rdw_mode_e;

  // A read colliding with a write to the same address returns the pre-write word.
  localparam rdw_mode_e RAM_RDW_MODE = RDW_OLD_DATA;

endpackage

// File: rtl/ram_512_if.sv
// Write/read port bundle of the frame-buffer RAM; the master drives addresses,
// enables and write data, the slave (the RAM) returns q.
interface ram_512_if
  import ram_512_pkg::*;
#(
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) ();

  logic [DATA_WIDTH-1:0] data;
  logic [ADDR_WIDTH-1:0] wraddress;
  logic                  wren;
  logic [ADDR_WIDTH-1:0] rdaddress;
  logic                  rden;
  logic [DATA_WIDTH-1:0] q;

  modport master (
    output data,
    output wraddress,
    output wren,
    output rdaddress,
    output rden,
    input  q
  );

  modport slave (
    input  data,
    input  wraddress,
    input  wren,
    input  rdaddress,
    input  rden,
    output q
  );

endinterface

// File: rtl/ram_512_chk.sv
// Simulation-only sanity checks on the RAM ports; flags unknown addresses that
// would make a write or read target an undefined word.
module ram_512_chk #(
  parameter int ADDR_WIDTH = 9
) (
  input logic                  clock,
  input logic                  rst_n,
  input logic                  wren,
  input logic [ADDR_WIDTH-1:0] wraddress,
  input logic                  rden,
  input logic [ADDR_WIDTH-1:0] rdaddress
);

  a_wraddr_known: assert property (@(posedge clock) disable iff (!rst_n)
                                   wren |-> !$isunknown(wraddress))
    else $error("ram_512: unknown write address while wren is high");

  a_rdaddr_known: assert property (@(posedge clock) disable iff (!rst_n)
                                   rden |-> !$isunknown(rdaddress))
    else $error("ram_512: unknown read address while rden is high");

endmodule

// File: rtl/ram_512_outreg.sv
// Optional second output stage of the frame-buffer RAM: copies the read register
// every cycle, cleared asynchronously with the rest of the read path.
module ram_512_outreg
  import ram_512_pkg::*;
#(
  parameter int DATA_WIDTH = RAM_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] q_r;

  // unconditional pipeline copy, no enable
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= '0;
    end else begin
      q_r <= d;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/ram_512.sv
// ram_512: simple dual-port frame buffer (one write, one read port, one clock).
// Same-address read/write returns the old word; OUT_REG=1 adds one cycle of read latency.
module ram_512
  import ram_512_pkg::*;
#(
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DEPTH      = 2 ** ADDR_WIDTH,
  parameter int OUT_REG    = 0
) (
  input logic      clock,
  input logic      rst_n,
  ram_512_if.slave bus
);

  logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic [DATA_WIDTH-1:0] q_s;

  // write port: rst_n only gates the enable, so the array never sees an async path
  always_ff @(posedge clock) begin
    if (rst_n && bus.wren) begin
      mem_r[bus.wraddress] <= bus.data;
    end
  end

  // read register: samples the pre-write word on a collision, holds while rden is low
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r <= '0;
    end else if (bus.rden) begin
      rd_data_r <= mem_r[bus.rdaddress];
    end
  end

  generate
    if (OUT_REG != 0) begin : g_outreg
      ram_512_outreg #(
        .DATA_WIDTH (DATA_WIDTH)
      ) u_outreg (
        .clock (clock),
        .rst_n (rst_n),
        .d     (rd_data_r),
        .q     (q_s)
      );
    end else begin : g_direct
      assign q_s = rd_data_r;
    end
  endgenerate

  assign bus.q = q_s;

  ram_512_chk #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_chk (
    .clock     (clock),
    .rst_n     (rst_n),
    .wren      (bus.wren),
    .wraddress (bus.wraddress),
    .rden      (bus.rden),
    .rdaddress (bus.rdaddress)
  );

endmodule

// File: tb/tb_ram_512.sv
// Self-checking bench for ram_512: directed cases followed by a full sweep and
// random traffic, all compared against an array-based reference of the RAM.
module tb_ram_512;
  import ram_512_pkg::*;

  localparam int OUT_REG = 0;
  localparam int DW      = 16;
  localparam int AW      = 9;
  localparam int DEPTH   = 512;

  logic clock = 1'b0;
  logic rst_n = 1'b0;

  int errors = 0;
  int checks = 0;

  // reference: memory contents plus the two read-path stages as plain values
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] rd_m;
  logic [DW-1:0] out_m;

  ram_512_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_512 #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .OUT_REG    (OUT_REG)
  ) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] q_exp();
    return (OUT_REG != 0) ? out_m : rd_m;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock: drive ports, let the edge happen, advance the reference, compare q
  task automatic step(input string tag, input logic we, input logic [AW-1:0] wa,
                      input logic [DW-1:0] d, input logic re, input logic [AW-1:0] ra);
    bus.wren      = we;
    bus.wraddress = wa;
    bus.data      = d;
    bus.rden      = re;
    bus.rdaddress = ra;
    @(posedge clock);
    if (rst_n) begin
      out_m = rd_m;
      if (re) rd_m = mem_m[ra];
      if (we) mem_m[wa] = d;
    end else begin
      rd_m  = '0;
      out_m = '0;
    end
    #1;
    check(tag, bus.q, q_exp());
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step("idle", 1'b0, 9'd0, 16'h0000, 1'b0, 9'd0);
  endtask

  initial begin
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] d;
    logic          we, re;

    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    rd_m  = '0;
    out_m = '0;
    bus.wren = 1'b0; bus.wraddress = '0; bus.data = '0;
    bus.rden = 1'b0; bus.rdaddress = '0;

    // power-on reset
    #1;
    check("reset_q", bus.q, 16'h0000);
    step("in_reset", 1'b0, 9'd0, 16'h0000, 1'b1, 9'd0);
    step("in_reset", 1'b0, 9'd0, 16'h0000, 1'b1, 9'd0);
    #2 rst_n = 1'b1;

    // preload words used by the directed cases
    step("preload", 1'b1, 9'd5,   16'h1234, 1'b0, 9'd0);
    step("preload", 1'b1, 9'd3,   16'h1111, 1'b0, 9'd0);
    step("preload", 1'b1, 9'd4,   16'h2222, 1'b0, 9'd0);
    step("preload", 1'b1, 9'd100, 16'h0001, 1'b0, 9'd0);
    step("preload", 1'b1, 9'd7,   16'h0777, 1'b0, 9'd0);

    // write-then-read at both address extremes
    wa = '1;
    step("wr_lo",   1'b1, 9'd0, 16'hA5A5, 1'b0, 9'd0);
    step("wr_hi",   1'b1, wa,   16'h5A5A, 1'b0, 9'd0);
    step("rd_lo",   1'b0, 9'd0, 16'h0000, 1'b1, 9'd0);
    step("rd_hi",   1'b0, 9'd0, 16'h0000, 1'b1, wa);
    step("rd_hi_l", 1'b0, 9'd0, 16'h0000, 1'b0, 9'd0);
    check("rd_511_value", bus.q, 16'h5A5A);

    // read-during-write returns the old word, the next read the new one
    step("rdw_same", 1'b1, 9'd100, 16'hBEEF, 1'b1, 9'd100);
    if (OUT_REG == 0) check("rdw_old_value", bus.q, 16'h0001);
    step("rdw_next", 1'b0, 9'd0, 16'h0000, 1'b1, 9'd100);
    if (OUT_REG != 0) check("rdw_old_value", bus.q, 16'h0001);
    idle(1);
    check("rdw_new_value", bus.q, 16'hBEEF);

    // rden low holds q while rdaddress moves
    step("hold_rd3", 1'b0, 9'd0, 16'h0000, 1'b1, 9'd3);
    for (int k = 0; k < 3; k++) step("hold", 1'b0, 9'd0, 16'h0000, 1'b0, 9'd4);
    check("rden_hold_value", bus.q, 16'h1111);
    step("hold_rd4", 1'b0, 9'd0, 16'h0000, 1'b1, 9'd4);
    idle(1);
    check("rden_resume_value", bus.q, 16'h2222);

    // wren low with data present must not write
    step("inhibit", 1'b0, 9'd7, 16'hFFFF, 1'b0, 9'd0);
    step("rd7",     1'b0, 9'd0, 16'h0000, 1'b1, 9'd7);
    idle(1);
    check("write_inhibit_value", bus.q, 16'h0777);

    // async reset mid-cycle, a write during reset is dropped, contents retained
    step("pre_rst", 1'b0, 9'd0, 16'h0000, 1'b1, 9'd4);
    #2 rst_n = 1'b0;
    rd_m  = '0;
    out_m = '0;
    #1;
    check("async_reset_q", bus.q, 16'h0000);
    step("rst_write", 1'b1, 9'd5, 16'hDEAD, 1'b1, 9'd5);
    #2 rst_n = 1'b1;
    step("post_rst", 1'b0, 9'd0, 16'h0000, 1'b1, 9'd5);
    idle(1);
    check("retained_after_reset", bus.q, 16'h1234);

    // full sweep: pattern i^0x5555 written in order, read back one cycle behind,
    // with occasional wren=0 cycles carrying junk data
    for (int i = 0; i <= DEPTH; i++) begin
      if ((i % 37) == 5) begin
        wa = 9'($urandom_range(0, DEPTH - 1));
        d  = 16'($urandom);
        step("sweep_nowr", 1'b0, wa, d, 1'b0, 9'd0);
      end
      wa = 9'(i);
      ra = 9'(i - 1);
      d  = 16'(i) ^ 16'h5555;
      we = (i < DEPTH);
      re = (i > 0);
      step("sweep", we, wa, d, re, ra);
    end
    for (int i = 0; i < DEPTH; i++) begin
      ra = 9'(i);
      step("sweep_verify", 1'b0, 9'd0, 16'h0000, 1'b1, ra);
    end

    // random traffic with frequent same-address collisions
    for (int n = 0; n < 600; n++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      wa = 9'($urandom_range(0, DEPTH - 1));
      ra = ($urandom_range(0, 3) == 0) ? wa : 9'($urandom_range(0, DEPTH - 1));
      d  = 16'($urandom);
      step("random", we, wa, d, re, ra);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
